// File: rtl/alu_operand_issue.sv
// ID/EX issue register for the ALU: forwards rs/rt, detects load-use hazards, inserts bubbles.
// Optional macro WB_FWD_EN enables the MEM/WB forwarding path (default: EX/MEM only).
module alu_operand_issue #(
  parameter int              DATA_W = 32,
  parameter int              OP_W   = 8,
  parameter logic [OP_W-1:0] NOP_OP = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [4:0]        id_wr_addr,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_fwd_en,
  input  logic [4:0]        mem_fwd_addr,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [4:0]        wb_fwd_addr,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_aluop,
  output logic [DATA_W-1:0] ex_num1,
  output logic [DATA_W-1:0] ex_num2,
  output logic [4:0]        ex_wr_addr,
  output logic              ex_is_load
);

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              bubble;

  function automatic logic [DATA_W-1:0] resolve(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              m_en,
    input logic [4:0]        m_addr,
    input logic [DATA_W-1:0] m_data,
    input logic              w_en,
    input logic [4:0]        w_addr,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] r;
    r = rf_data;
    // $0 is hard-wired: never take a bypass for it. EX/MEM is younger, so it wins.
    if (addr != 5'd0) begin
      if (m_en && m_addr == addr)      r = m_data;
      else if (w_en && w_addr == addr) r = w_data;
    end
    return r;
  endfunction

`ifdef WB_FWD_EN
  always_comb begin
    rs_fwd = resolve(id_rs_addr, id_rs_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                     wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    rt_fwd = resolve(id_rt_addr, id_rt_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                     wb_fwd_en, wb_fwd_addr, wb_fwd_data);
  end
`else
  // Without the WB path the register file is write-first, so WB data is already in id_*_data.
  logic unused_wb;
  assign unused_wb = ^{wb_fwd_en, wb_fwd_addr, wb_fwd_data};

  always_comb begin
    rs_fwd = resolve(id_rs_addr, id_rs_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                     1'b0, 5'd0, '0);
    rt_fwd = resolve(id_rt_addr, id_rt_data, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                     1'b0, 5'd0, '0);
  end
`endif

  // A load's data is not ready in EX, so a dependent instruction must wait one cycle.
  assign stall = id_valid & ex_valid & ex_is_load & (ex_wr_addr != 5'd0) &
                 ((ex_wr_addr == id_rs_addr) | (~id_use_imm & (ex_wr_addr == id_rt_addr)));

  assign bubble = flush | stall | ~id_valid;

  // NOTE: state registers use non-blocking assignments so all fields update together at the edge.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex_valid   <= 1'b0;
      ex_aluop   <= NOP_OP;
      ex_num1    <= '0;
      ex_num2    <= '0;
      ex_wr_addr <= 5'd0;
      ex_is_load <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_aluop   <= id_aluop;
      ex_num1    <= rs_fwd;
      ex_num2    <= id_use_imm ? id_imm : rt_fwd;
      ex_wr_addr <= id_wr_addr;
      ex_is_load <= id_is_load;
    end
  end

endmodule
